fu_output_queue: RTL and testbench

Parametrised successor to the single-slot FU output stage. It broadcasts each functional-unit result to the CDB (tag and value) and to the ROB (robid, flags, wbs, value). Each destination arbitrates through the daisy-chained transmit signals and has its own DEPTH-entry FIFO, so the FU can keep issuing while either bus is held by upstream units. It sits between an FU datapath and the CDB/ROB priority chains.

---
 rtl/fu_output_queue.sv | 158 +++++++++++++++
 tb/tb_fu_output_queue.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fu_output_queue.sv
// FU output stage with per-destination FIFOs for the CDB and ROB priority chains.
// Optional stall counters are enabled by defining FU_OUT_STATS_EN.

module fu_oq_lane #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid,
  input  logic [W-1:0]               data,
  input  logic                       transmit,
  output logic                       transmit_out,
  output logic [W-1:0]               grant_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       drop
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic          empty, full, req, grant, pop, push_req, push;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign req      = valid | ~empty;
  assign grant    = req & ~transmit;
  assign pop      = grant & ~empty;
  // Live input skips the FIFO only when nothing older is queued and the bus is free.
  assign push_req = valid & ~(empty & grant);
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  assign transmit_out = transmit | req;
  assign grant_data   = grant ? (empty ? data : mem[rd_ptr]) : '0;
  assign count        = count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data;
  end
endmodule

module fu_output_queue #(
  parameter int DATA_W  = 8,
  parameter int TAG_W   = 4,
  parameter int ROBID_W = 4,
  parameter int FLAGS_W = 8,
  parameter int WBS_W   = 8,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       input_transmit,
  input  logic                       cdb_write_en,
  input  logic [WBS_W-1:0]           wbs,
  input  logic [FLAGS_W-1:0]         flags,
  input  logic [ROBID_W-1:0]         robid,
  input  logic [DATA_W-1:0]          result,
  input  logic                       cdb_transmit,
  output logic                       cdb_transmit_out,
  output logic [TAG_W-1:0]           cdb_id,
  output logic [DATA_W-1:0]          cdb_val,
  input  logic                       rob_transmit,
  output logic                       rob_transmit_out,
  output logic [ROBID_W-1:0]         robid_out,
  output logic [FLAGS_W-1:0]         flags_out,
  output logic [WBS_W-1:0]           wbs_out,
  output logic [DATA_W-1:0]          value_out,
  output logic [$clog2(DEPTH+1)-1:0] cdb_count,
  output logic [$clog2(DEPTH+1)-1:0] rob_count,
  output logic                       busy,
  output logic                       overflow
`ifdef FU_OUT_STATS_EN
  ,
  output logic [15:0]                cdb_stall_cnt,
  output logic [15:0]                rob_stall_cnt
`endif
);
  localparam int CW    = $clog2(DEPTH+1);
  localparam int CDB_W = TAG_W + DATA_W;
  localparam int ROB_W = ROBID_W + FLAGS_W + WBS_W + DATA_W;

  logic             live, cdb_in, cdb_drop, rob_drop;
  logic [CDB_W-1:0] cdb_data;
  logic [ROB_W-1:0] rob_data;

  // Gating with reset keeps bypass outputs at zero while reset is held.
  assign live   = input_transmit & rst;
  assign cdb_in = live & cdb_write_en;

  fu_oq_lane #(.W(CDB_W), .DEPTH(DEPTH)) u_cdb (
    .clk          (clk),
    .rst          (rst),
    .valid        (cdb_in),
    .data         ({wbs[TAG_W-1:0], result}),
    .transmit     (cdb_transmit),
    .transmit_out (cdb_transmit_out),
    .grant_data   (cdb_data),
    .count        (cdb_count),
    .drop         (cdb_drop)
  );

  fu_oq_lane #(.W(ROB_W), .DEPTH(DEPTH)) u_rob (
    .clk          (clk),
    .rst          (rst),
    .valid        (live),
    .data         ({robid, flags, wbs, result}),
    .transmit     (rob_transmit),
    .transmit_out (rob_transmit_out),
    .grant_data   (rob_data),
    .count        (rob_count),
    .drop         (rob_drop)
  );

  assign {cdb_id, cdb_val}                         = cdb_data;
  assign {robid_out, flags_out, wbs_out, value_out} = rob_data;

  assign busy = (cdb_count >= CW'(DEPTH-1)) | (rob_count >= CW'(DEPTH-1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      overflow <= 1'b0;
    else if (cdb_drop | rob_drop)  overflow <= 1'b1;
  end

`ifdef FU_OUT_STATS_EN
  logic cdb_stall, rob_stall;
  assign cdb_stall = cdb_transmit & (cdb_in | (cdb_count != '0));
  assign rob_stall = rob_transmit & (live | (rob_count != '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_stall_cnt <= '0;
      rob_stall_cnt <= '0;
    end else begin
      if (cdb_stall && cdb_stall_cnt != '1) cdb_stall_cnt <= cdb_stall_cnt + 16'd1;
      if (rob_stall && rob_stall_cnt != '1) rob_stall_cnt <= rob_stall_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fu_output_queue.sv
// Table-driven bench for fu_output_queue with a queue scoreboard for CDB/ROB emissions.
module tb_fu_output_queue;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       input_transmit = 1'b0, cdb_write_en = 1'b0;
  logic [7:0] wbs = '0, flags = '0, result = '0;
  logic [3:0] robid = '0;
  logic       cdb_transmit = 1'b0, rob_transmit = 1'b0;
  logic       cdb_transmit_out, rob_transmit_out, busy, overflow;
  logic [3:0] cdb_id, robid_out;
  logic [7:0] cdb_val, flags_out, wbs_out, value_out;
  logic [2:0] cdb_count, rob_count;
`ifdef FU_OUT_STATS_EN
  logic [15:0] cdb_stall_cnt, rob_stall_cnt;
`endif

  fu_output_queue #(.DATA_W(8), .TAG_W(4), .ROBID_W(4), .FLAGS_W(8), .WBS_W(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .input_transmit(input_transmit), .cdb_write_en(cdb_write_en),
    .wbs(wbs), .flags(flags), .robid(robid), .result(result),
    .cdb_transmit(cdb_transmit), .cdb_transmit_out(cdb_transmit_out),
    .cdb_id(cdb_id), .cdb_val(cdb_val),
    .rob_transmit(rob_transmit), .rob_transmit_out(rob_transmit_out),
    .robid_out(robid_out), .flags_out(flags_out), .wbs_out(wbs_out), .value_out(value_out),
    .cdb_count(cdb_count), .rob_count(rob_count), .busy(busy), .overflow(overflow)
`ifdef FU_OUT_STATS_EN
    , .cdb_stall_cnt(cdb_stall_cnt), .rob_stall_cnt(rob_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       itx, we;
    logic [7:0] wbs, res;
    logic [3:0] id;
    logic       ct, rt;
    int         cc, rc;   // expected counts at sample time; -1 skips
    logic       busy, ovf;
  } vec_t;

  vec_t        tbl[$];
  logic [11:0] qc[$];
  logic [27:0] qr[$];
  int          total = 0, passed = 0;

  function automatic vec_t mk(logic itx, logic we, logic [7:0] w, logic [7:0] r, logic [3:0] id,
                              logic ct, logic rt, int cc, int rc, logic b, logic o);
    vec_t v;
    v.itx = itx; v.we = we; v.wbs = w; v.res = r; v.id = id; v.ct = ct; v.rt = rt;
    v.cc = cc; v.rc = rc; v.busy = b; v.ovf = o;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Drives one cycle, checks combinational outputs against the scoreboard, then advances past the edge.
  task automatic step(input vec_t v);
    logic        cin, creq, cgr, cempty, cfull, rreq, rgr, rempty, rfull;
    logic [11:0] citem;
    logic [27:0] ritem;
    input_transmit = v.itx; cdb_write_en = v.we; wbs = v.wbs; result = v.res;
    flags = ~v.res; robid = v.id; cdb_transmit = v.ct; rob_transmit = v.rt;
    @(negedge clk);
    if (v.cc >= 0) begin
      chk("cdb_count", 32'(cdb_count), 32'(v.cc));
      chk("rob_count", 32'(rob_count), 32'(v.rc));
      chk("busy", 32'(busy), 32'(v.busy));
      chk("overflow", 32'(overflow), 32'(v.ovf));
    end
    citem  = {v.wbs[3:0], v.res};
    ritem  = {v.id, ~v.res, v.wbs, v.res};
    cin    = v.itx & v.we;
    cempty = (qc.size() == 0);
    cfull  = (qc.size() == DEPTH);
    creq   = cin | ~cempty;
    cgr    = creq & ~v.ct;
    chk("cdb_transmit_out", 32'(cdb_transmit_out), 32'(v.ct | creq));
    chk("cdb_data", 32'({cdb_id, cdb_val}), cgr ? 32'(cempty ? citem : qc[0]) : 32'd0);
    if (cgr && !cempty) void'(qc.pop_front());
    if (cin && !(cempty && cgr) && (!cfull || (cgr && !cempty))) qc.push_back(citem);
    rempty = (qr.size() == 0);
    rfull  = (qr.size() == DEPTH);
    rreq   = v.itx | ~rempty;
    rgr    = rreq & ~v.rt;
    chk("rob_transmit_out", 32'(rob_transmit_out), 32'(v.rt | rreq));
    chk("rob_data", 32'({robid_out, flags_out, wbs_out, value_out}), rgr ? 32'(rempty ? ritem : qr[0]) : 32'd0);
    if (rgr && !rempty) void'(qr.pop_front());
    if (v.itx && !(rempty && rgr) && (!rfull || (rgr && !rempty))) qr.push_back(ritem);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // bypass
    tbl.push_back(mk(1,1,8'h05,8'hA7,4'd3,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,8'h00,8'h00,4'd0,0,0, 0,0,0,0));
    // CDB blocked for three results, ROB bypasses
    tbl.push_back(mk(1,1,8'h01,8'hA1,4'd1,1,0, 0,0,0,0));
    tbl.push_back(mk(1,1,8'h02,8'hA2,4'd2,1,0, 1,0,0,0));
    tbl.push_back(mk(1,1,8'h03,8'hA3,4'd3,1,0, 2,0,0,0));
    tbl.push_back(mk(0,0,8'h00,8'h00,4'd0,0,0, 3,0,1,0));
    tbl.push_back(mk(0,0,8'h00,8'h00,4'd0,0,0, 2,0,0,0));
    tbl.push_back(mk(0,0,8'h00,8'h00,4'd0,0,0, 1,0,0,0));
    tbl.push_back(mk(0,0,8'h00,8'h00,4'd0,0,0, 0,0,0,0));
    // no CDB write, ROB held one cycle
    tbl.push_back(mk(1,0,8'h44,8'h5B,4'd6,1,1, 0,0,0,0));
    tbl.push_back(mk(0,0,8'h00,8'h00,4'd0,0,0, 0,1,0,0));
    tbl.push_back(mk(0,0,8'h00,8'h00,4'd0,0,0, 0,0,0,0));
    // fill CDB, full with pop, then full without pop (dropped)
    tbl.push_back(mk(1,1,8'h10,8'h11,4'd1,1,0, 0,0,0,0));
    tbl.push_back(mk(1,1,8'h11,8'h12,4'd2,1,0, 1,0,0,0));
    tbl.push_back(mk(1,1,8'h12,8'h13,4'd3,1,0, 2,0,0,0));
    tbl.push_back(mk(1,1,8'h13,8'h14,4'd4,1,0, 3,0,1,0));
    tbl.push_back(mk(1,1,8'h1F,8'h55,4'd5,0,0, 4,0,1,0));
    tbl.push_back(mk(1,1,8'h1E,8'h66,4'd6,1,0, 4,0,1,0));
    tbl.push_back(mk(0,0,8'h00,8'h00,4'd0,1,0, 4,0,1,1));
    tbl.push_back(mk(0,0,8'h00,8'h00,4'd0,0,0, 4,0,1,1));
    tbl.push_back(mk(0,0,8'h00,8'h00,4'd0,0,0, 3,0,1,1));
    tbl.push_back(mk(0,0,8'h00,8'h00,4'd0,0,0, 2,0,0,1));
    tbl.push_back(mk(0,0,8'h00,8'h00,4'd0,0,0, 1,0,0,1));
    tbl.push_back(mk(0,0,8'h00,8'h00,4'd0,0,0, 0,0,0,1));
    tbl.push_back(mk(0,0,8'h00,8'h00,4'd0,0,0, 0,0,0,1));

    repeat (3) @(posedge clk);
    #1;
    chk("reset_cdb_count", 32'(cdb_count), 32'd0);
    chk("reset_outputs", 32'({cdb_id, cdb_val, cdb_transmit_out, rob_transmit_out, busy, overflow}), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // async reset with two queued CDB entries and live inputs still asserted
    step(mk(1,1,8'h07,8'hC1,4'd1,1,0, 0,0,0,1));
    step(mk(1,1,8'h08,8'hC2,4'd2,1,0, 1,0,0,1));
    chk("pre_reset_cdb_count", 32'(cdb_count), 32'd2);
    input_transmit = 1'b1; cdb_write_en = 1'b1; cdb_transmit = 1'b1; rob_transmit = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async_counts", 32'({cdb_count, rob_count}), 32'd0);
    chk("async_overflow", 32'(overflow), 32'd0);
    chk("async_cdb_data", 32'({cdb_id, cdb_val}), 32'd0);
    chk("async_rob_data", 32'({robid_out, flags_out, wbs_out, value_out}), 32'd0);
    chk("async_tx_follow", 32'({cdb_transmit_out, rob_transmit_out}), 32'b10);
    cdb_transmit = 1'b0; rob_transmit = 1'b1;
    #1;
    chk("async_tx_follow2", 32'({cdb_transmit_out, rob_transmit_out}), 32'b01);
    qc.delete(); qr.delete();
    input_transmit = 1'b0; cdb_write_en = 1'b0; rob_transmit = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;

    // ROB held ten cycles with one queued entry; discarded CDB entries must not reappear
    step(mk(1,0,8'h09,8'h3D,4'd9,0,1, 0,0,0,0));
    for (int i = 0; i < 9; i++) step(mk(0,0,8'h00,8'h00,4'd0,0,1, 0,1,0,0));
`ifdef FU_OUT_STATS_EN
    chk("rob_stall_cnt", 32'(rob_stall_cnt), 32'd10);
    chk("cdb_stall_cnt", 32'(cdb_stall_cnt), 32'd0);
`endif
    step(mk(0,0,8'h00,8'h00,4'd0,0,0, 0,1,0,0));
    step(mk(0,0,8'h00,8'h00,4'd0,0,0, 0,0,0,0));
`ifdef FU_OUT_STATS_EN
    chk("rob_stall_hold", 32'(rob_stall_cnt), 32'd10);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
